led_pwm_driver: RTL and testbench

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

---
 rtl/led_pwm_driver.sv | 173 +++++++++++++++++
 tb/tb_led_pwm_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: four-channel LED PWM driver with steady, blink and optional fade modes.
// Commands are staged in a pending slot and applied at a PWM period boundary.
// Optional fade support is compiled in with macro LED_PWM_FADE_EN; without it mode 11 acts as steady.
module led_pwm_driver #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned BLINK_DIV = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_led,
  input  logic [1:0]          i_cmd_mode,
  input  logic [PWM_BITS-1:0] i_cmd_duty,
  output logic                o_led_blue,
  output logic                o_led_green,
  output logic                o_led_orange,
  output logic                o_led_red
);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
`ifdef LED_PWM_FADE_EN
  localparam logic [1:0] MODE_FADE   = 2'b11;
`endif
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_PEND     = 1'b1;
  localparam logic [PWM_BITS-1:0]  CNT_MAX   = '1;
  localparam logic [BLINK_DIV-1:0] BLINK_MAX = '1;

  logic [PWM_BITS-1:0]  cnt_q;
  logic [BLINK_DIV-1:0] blink_cnt_q;
  logic                 blink_phase_q;
  logic                 wrap;
  logic                 accept;
  logic                 apply;
  logic [0:0]           state_q;
  logic [0:0]           state_d;
  logic [1:0]           pend_led_q;
  logic [1:0]           pend_mode_q;
  logic [PWM_BITS-1:0]  pend_duty_q;
  logic [1:0]           mode_q [4];
  logic [PWM_BITS-1:0]  duty_q [4];
  logic [PWM_BITS-1:0]  eff_duty [4];
  logic [3:0]           gate;
  logic [3:0]           led_d;
  logic [3:0]           led_q;
`ifdef LED_PWM_FADE_EN
  logic [PWM_BITS-1:0]  level_q [4];
  logic [3:0]           up_q;
`endif

  assign wrap   = (cnt_q == CNT_MAX);
  assign accept = i_cmd_valid && o_cmd_ready && !i_rst;
  assign apply  = (state_q == ST_PEND) && wrap && !i_rst;

  // Next-state logic: wait in PEND until the next period boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PEND;
      ST_PEND: if (wrap)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with registered ready flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      o_cmd_ready <= 1'b1;
    end else begin
      state_q     <= state_d;
      o_cmd_ready <= (state_d == ST_IDLE);
    end
  end

  // Free-running PWM counter and shared blink phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_q + PWM_BITS'(1);
      blink_cnt_q <= blink_cnt_q + BLINK_DIV'(1);
      if (blink_cnt_q == BLINK_MAX) blink_phase_q <= ~blink_phase_q;
    end
  end

  // Pending command slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_led_q  <= '0;
      pend_mode_q <= '0;
      pend_duty_q <= '0;
    end else if (accept) begin
      pend_led_q  <= i_cmd_led;
      pend_mode_q <= i_cmd_mode;
      pend_duty_q <= i_cmd_duty;
    end
  end

  // Per-LED active mode and duty, loaded from the pending slot at the boundary.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_rst) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
      end else if (apply && (pend_led_q == 2'(i))) begin
        mode_q[i] <= pend_mode_q;
        duty_q[i] <= pend_duty_q;
      end
    end
  end

`ifdef LED_PWM_FADE_EN
  // Fade level: triangle between 0 and duty, one step per PWM period.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_rst) begin
        level_q[i] <= '0;
        up_q[i]    <= 1'b1;
      end else if (apply && (pend_led_q == 2'(i))) begin
        level_q[i] <= '0;
        up_q[i]    <= 1'b1;
      end else if (wrap && (mode_q[i] == MODE_FADE)) begin
        if (duty_q[i] == '0) begin
          level_q[i] <= '0;
        end else if (up_q[i]) begin
          if (level_q[i] < duty_q[i]) begin
            level_q[i] <= level_q[i] + PWM_BITS'(1);
          end else begin
            level_q[i] <= level_q[i] - PWM_BITS'(1);
            up_q[i]    <= 1'b0;
          end
        end else begin
          if (level_q[i] != '0) begin
            level_q[i] <= level_q[i] - PWM_BITS'(1);
          end else begin
            level_q[i] <= level_q[i] + PWM_BITS'(1);
            up_q[i]    <= 1'b1;
          end
        end
      end
    end
  end
`endif

  // PWM compare against the effective duty, gated by blink phase.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eff_duty[i] = duty_q[i];
`ifdef LED_PWM_FADE_EN
      if (mode_q[i] == MODE_FADE) eff_duty[i] = level_q[i];
`endif
      gate[i]  = (mode_q[i] == MODE_BLINK) ? blink_phase_q : 1'b1;
      led_d[i] = (mode_q[i] != MODE_OFF) && (cnt_q < eff_duty[i]) && gate[i];
    end
  end

  // Registered LED pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) led_q <= '0;
    else       led_q <= led_d;
  end

  assign o_led_blue   = led_q[0];
  assign o_led_green  = led_q[1];
  assign o_led_orange = led_q[2];
  assign o_led_red    = led_q[3];

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: directed bench for led_pwm_driver (PWM_BITS=4, BLINK_DIV=6).
// Expected pins come from a cycle model pushed into a scoreboard queue; define
// LED_PWM_FADE_EN for both files to exercise fade mode.
module tb_led_pwm_driver;

  localparam int unsigned PB = 4;
  localparam int unsigned BD = 6;
  localparam int PER = 16;
  localparam int BLK = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [1:0]    cmd_led;
  logic [1:0]    cmd_mode;
  logic [PB-1:0] cmd_duty;
  logic          led_b, led_g, led_o, led_r;

  always #5 clk = ~clk;

  led_pwm_driver #(.PWM_BITS(PB), .BLINK_DIV(BD)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready),
    .i_cmd_led(cmd_led), .i_cmd_mode(cmd_mode), .i_cmd_duty(cmd_duty),
    .o_led_blue(led_b), .o_led_green(led_g), .o_led_orange(led_o), .o_led_red(led_r)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_cnt, m_bcnt, p_duty;
  bit m_phase, m_pend, m_ready;
  int p_led, p_mode;
  int m_mode [4];
  int m_duty [4];
  int m_level [4];
  bit m_up [4];
  bit [3:0] m_leds;

  logic [4:0] sb [$];
  int hi [4];
  int ready_low;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Predict the pins after the coming clock edge from the current inputs.
  task automatic model_step();
    bit [3:0] nl;
    bit wrap, acc, app;
    int eff;
    nl = '0;
    if (rst) begin
      m_cnt = 0; m_bcnt = 0; m_phase = 0; m_pend = 0;
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = 0; m_duty[i] = 0; m_level[i] = 0; m_up[i] = 1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        eff = m_duty[i];
`ifdef LED_PWM_FADE_EN
        if (m_mode[i] == 3) eff = m_level[i];
`endif
        nl[i] = (m_mode[i] != 0) && (m_cnt < eff) && ((m_mode[i] == 2) ? m_phase : 1'b1);
      end
      wrap = (m_cnt == PER - 1);
      acc  = valid && !m_pend;
      app  = m_pend && wrap;
`ifdef LED_PWM_FADE_EN
      if (wrap) begin
        for (int i = 0; i < 4; i++) begin
          if (m_mode[i] == 3) begin
            if (m_duty[i] == 0) m_level[i] = 0;
            else if (m_up[i]) begin
              if (m_level[i] < m_duty[i]) m_level[i]++;
              else begin m_level[i]--; m_up[i] = 0; end
            end else begin
              if (m_level[i] > 0) m_level[i]--;
              else begin m_level[i]++; m_up[i] = 1; end
            end
          end
        end
      end
`endif
      if (app) begin
        m_mode[p_led] = p_mode; m_duty[p_led] = p_duty;
        m_level[p_led] = 0; m_up[p_led] = 1; m_pend = 0;
      end else if (acc) begin
        p_led = int'(cmd_led); p_mode = int'(cmd_mode); p_duty = int'(cmd_duty);
        m_pend = 1;
      end
      m_cnt = (m_cnt + 1) % PER;
      if (m_bcnt == BLK - 1) m_phase = ~m_phase;
      m_bcnt = (m_bcnt + 1) % BLK;
    end
    m_leds  = nl;
    m_ready = !m_pend;
    sb.push_back({m_ready, m_leds});
  endtask

  // One clock: predict, clock, pop and compare.
  task automatic cycle();
    logic [4:0] exp, obs;
    model_step();
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    obs = {ready, led_r, led_o, led_g, led_b};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL pins t=%0t observed=%b expected=%b", $time, obs, exp);
    end
    hi[0] += int'(led_b); hi[1] += int'(led_g);
    hi[2] += int'(led_o); hi[3] += int'(led_r);
    if (ready !== 1'b1) ready_low++;
  endtask

  task automatic clear_hi();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    ready_low = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic send(input int l, input int md, input int d);
    valid = 1'b1; cmd_led = 2'(l); cmd_mode = 2'(md); cmd_duty = PB'(d);
    cycle();
    valid = 1'b0; cmd_led = '0; cmd_mode = '0; cmd_duty = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    if (ready !== 1'b1) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int per_hi [8];
    int n;
    rst = 1'b1; valid = 1'b0; cmd_led = '0; cmd_mode = '0; cmd_duty = '0;
    run(3);
    chk("reset_ready", int'(ready), 1);
    chk("reset_leds", int'({led_r, led_o, led_g, led_b}), 0);
    rst = 1'b0;

    // steady duty 4 on blue; ready drops until the next wrap
    send(0, 1, 4);
    chk("steady4_ready_low", int'(ready), 0);
    wait_idle("steady4");
    clear_hi();
    run(32);
    chk("steady4_blue", hi[0], 8);
    chk("steady4_green", hi[1], 0);
    chk("steady4_orange", hi[2], 0);
    chk("steady4_red", hi[3], 0);

    // duty extremes
    send(0, 1, 0);
    wait_idle("duty0");
    clear_hi();
    run(32);
    chk("duty0_blue", hi[0], 0);
    send(0, 1, 15);
    wait_idle("duty15");
    clear_hi();
    run(32);
    chk("duty15_blue", hi[0], 30);

    // command accepted exactly in the wrap cycle
    n = 0;
    while (m_cnt != PER - 1 && n < 32) begin cycle(); n++; end
    chk("wrap_align", m_cnt, PER - 1);
    clear_hi();
    send(0, 1, 8);
    wait_idle("wrapcmd");
    chk("wrapcmd_ready_low", ready_low, 16);
    clear_hi();
    run(16);
    chk("wrapcmd_blue", hi[0], 8);

    // blink on red, duty 8
    send(3, 2, 8);
    wait_idle("blink");
    clear_hi();
    run(128);
    chk("blink_red", hi[3], 32);
    chk("blink_blue", hi[0], 64);

    // fade on green, duty 3; period counts start right after the apply edge
    send(1, 3, 3);
    wait_idle("fade");
    for (int p = 0; p < 8; p++) begin
      clear_hi();
      run(16);
      per_hi[p] = hi[1];
    end
`ifdef LED_PWM_FADE_EN
    chk("fade_p0", per_hi[0], 0);
    chk("fade_p1", per_hi[1], 1);
    chk("fade_p2", per_hi[2], 2);
    chk("fade_p3", per_hi[3], 3);
    chk("fade_p4", per_hi[4], 2);
    chk("fade_p5", per_hi[5], 1);
    chk("fade_p6", per_hi[6], 0);
    chk("fade_p7", per_hi[7], 1);
`else
    for (int p = 0; p < 8; p++) chk($sformatf("fade_as_steady_p%0d", p), per_hi[p], 3);
`endif

    // reset while a command is pending
    send(2, 1, 10);
    chk("pend_ready_low", int'(ready), 0);
    run(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_pend_ready", int'(ready), 1);
    chk("rst_pend_leds", int'({led_r, led_o, led_g, led_b}), 0);
    clear_hi();
    run(40);
    chk("rst_pend_orange", hi[2], 0);
    chk("rst_pend_all", hi[0] + hi[1] + hi[3], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
